// File: rtl/ifmap_spad_ctrl.sv
// IFMap scratchpad sequencer: circular write pointer plus 1-D sliding-window read address generator.
// Latency: a written element can be read on the next cycle. start->busy and window-end->done each take one cycle.
// Backpressure: in_ready drops when the row is fully written or the buffer holds SPAD_ROW live elements. Taps wait for rd_ready.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   start, cfg_len/filt/stride   row command (L, K, S), sampled in IDLE only
//   in_valid/in_ready            element stream from the input FIFO
//   spad_wen/spad_waddr          scratchpad write strobe and address
//   spad_raddr/rd_valid/rd_ready/rd_last   tap address stream toward the PE MAC
//   busy, done, cfg_err          status; cfg_err stays set until the next start
//   stall_cnt                    read-starve cycle counter
// Optional feature: define IFMAP_CTRL_PERF_EN to enable stall_cnt. When it is undefined, stall_cnt reads 0.

module ifmap_spad_ctrl #(
    parameter int SPAD_ROW   = 12,
    parameter int SPAD_WIDTH = 16,
    parameter int LEN_W      = 8,
    parameter int STRIDE_W   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LEN_W-1:0]              cfg_len,
    input  logic [$clog2(SPAD_ROW+1)-1:0] cfg_filt,
    input  logic [STRIDE_W-1:0]           cfg_stride,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          spad_wen,
    output logic [$clog2(SPAD_ROW)-1:0]   spad_waddr,
    output logic [$clog2(SPAD_ROW)-1:0]   spad_raddr,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic                          rd_last,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err,
    output logic [15:0]                   stall_cnt
);

    localparam int AW  = $clog2(SPAD_ROW);
    localparam int AW1 = AW + 1;
    localparam int KW  = $clog2(SPAD_ROW + 1);
    // One extra bit so win_start can step past L, and win_start+K stays representable.
    localparam int CW  = LEN_W + 1;

    // Data never passes through this block. SPAD_WIDTH is checked only for a sane setting.
    if (SPAD_WIDTH < 1 || SPAD_ROW < 2) begin : g_bad_param
        $error("ifmap_spad_ctrl: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [LEN_W-1:0]      len_q;
    logic [KW-1:0]         filt_q;
    logic [STRIDE_W-1:0]   stride_q;
    logic [AW-1:0]         stride_mod_q;   // S mod SPAD_ROW, computed once per row
    logic [LEN_W-1:0]      wr_cnt;
    logic [CW-1:0]         win_start;
    logic [KW-1:0]         k;
    logic [AW-1:0]         wptr;           // wr_cnt mod SPAD_ROW
    logic [AW-1:0]         rbase;          // win_start mod SPAD_ROW
    logic                  win_fin;        // every window of the row has retired

    logic                  run;
    logic [CW-1:0]         wr_ext;
    logic [CW-1:0]         tap_idx;
    logic [CW-1:0]         occ;
    logic [CW-1:0]         win_next;
    logic [AW1-1:0]        raddr_sum;
    logic [AW1-1:0]        rbase_sum;
    logic [AW-1:0]         rbase_next;
    logic                  tap_last;
    logic                  cfg_bad;
    logic                  wr_fire;
    logic                  rd_fire;

    always_comb begin
        run       = (state == RUN);
        wr_ext    = CW'(wr_cnt);
        tap_idx   = win_start + CW'(k);
        // If the stride is larger than the filter, win_start can run ahead of wr_cnt. Occupancy is then 0.
        occ       = (wr_ext > win_start) ? (wr_ext - win_start) : '0;
        win_next  = win_start + CW'(stride_q);

        // rbase and k are each below SPAD_ROW, so a single subtract wraps the sum.
        raddr_sum  = AW1'(rbase) + AW1'(k);
        spad_raddr = (raddr_sum >= AW1'(SPAD_ROW)) ? AW'(raddr_sum - AW1'(SPAD_ROW))
                                                   : AW'(raddr_sum);
        rbase_sum  = AW1'(rbase) + AW1'(stride_mod_q);
        rbase_next = (rbase_sum >= AW1'(SPAD_ROW)) ? AW'(rbase_sum - AW1'(SPAD_ROW))
                                                   : AW'(rbase_sum);

        spad_waddr = wptr;
        in_ready   = run && (wr_cnt < len_q) && (occ < CW'(SPAD_ROW));
        spad_wen   = in_valid && in_ready;
        // wr_cnt is the registered count. An element written this cycle becomes visible next cycle.
        rd_valid   = run && !win_fin && (tap_idx < wr_ext);
        tap_last   = (k == filt_q - KW'(1));
        rd_last    = rd_valid && tap_last;

        wr_fire    = spad_wen;
        rd_fire    = rd_valid && rd_ready;

        cfg_bad    = (cfg_filt == '0) || (cfg_stride == '0) ||
                     (cfg_filt > KW'(SPAD_ROW)) || (cfg_len < LEN_W'(cfg_filt));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            len_q        <= '0;
            filt_q       <= '0;
            stride_q     <= '0;
            stride_mod_q <= '0;
            wr_cnt       <= '0;
            win_start    <= '0;
            k            <= '0;
            wptr         <= '0;
            rbase        <= '0;
            win_fin      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_err <= cfg_bad;
                        if (cfg_bad) begin
                            // Report the bad row without touching the scratchpad.
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= RUN;
                            busy         <= 1'b1;
                            len_q        <= cfg_len;
                            filt_q       <= cfg_filt;
                            stride_q     <= cfg_stride;
                            stride_mod_q <= AW'(int'(cfg_stride) % SPAD_ROW);
                            wr_cnt       <= '0;
                            win_start    <= '0;
                            k            <= '0;
                            wptr         <= '0;
                            rbase        <= '0;
                            win_fin      <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // Finish only after the tail of the row has been drained from the input.
                    if (win_fin && (wr_cnt == len_q)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    if (wr_fire) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        wptr   <= (wptr == AW'(SPAD_ROW - 1)) ? '0 : wptr + 1'b1;
                    end
                    if (rd_fire) begin
                        if (tap_last) begin
                            k         <= '0;
                            win_start <= win_next;
                            rbase     <= rbase_next;
                            win_fin   <= (win_next + CW'(filt_q)) > CW'(len_q);
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IFMAP_CTRL_PERF_EN
    // Count RUN cycles in which the PE waits for input data, because a window is still open but its next tap is not yet written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if (run && !win_fin && !rd_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifmap_spad_ctrl.sv
// Self-checking bench for ifmap_spad_ctrl. It uses fixed rows and randomized rows.
// A transaction-level row model (absolute element, window and tap indices) predicts each output on every cycle.
// Outputs are sampled on the falling edge. Inputs are driven 1 ns after the rising edge.
module tb_ifmap_spad_ctrl;

    localparam int SR = 12;
    localparam int LW = 8;
    localparam int SW = 4;
    localparam int AW = $clog2(SR);
    localparam int KW = $clog2(SR + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic [KW-1:0] cfg_filt = '0;
    logic [SW-1:0] cfg_stride = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          spad_wen;
    logic [AW-1:0] spad_waddr;
    logic [AW-1:0] spad_raddr;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic          rd_last;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [15:0]   stall_cnt;

    ifmap_spad_ctrl #(.SPAD_ROW(SR), .SPAD_WIDTH(16), .LEN_W(LW), .STRIDE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_len(cfg_len), .cfg_filt(cfg_filt), .cfg_stride(cfg_stride),
        .in_valid(in_valid), .in_ready(in_ready),
        .spad_wen(spad_wen), .spad_waddr(spad_waddr), .spad_raddr(spad_raddr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .busy(busy), .done(done), .cfg_err(cfg_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Row model: 0 = idle, 1 = running, 2 = done pulse.
    int m_state = 0;
    int m_L = 0, m_K = 0, m_S = 0;
    int m_wr = 0, m_win = 0, m_k = 0;
    bit m_fin = 0, m_err = 0;
    int m_stall = 0;

    // Observations from the DUT, collected for the scenario checks.
    int rq[$];
    int lq[$];
    int wq[$];
    int n_wen_obs, n_rv_obs, n_win_obs, n_done_obs, wen_at_hold;

    int e1[9] = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
    int e3[4] = '{0, 1, 3, 4};

    task automatic step(input bit vin, input bit rrdy, input bit st);
        int occ;
        bit e_ir, e_rv, e_last, wf, rf, bad;
        in_valid = vin;
        rd_ready = rrdy;
        start    = st;
        @(negedge clk);
        occ    = m_wr - m_win;
        if (occ < 0) occ = 0;
        e_ir   = (m_state == 1) && (m_wr < m_L) && (occ < SR);
        e_rv   = (m_state == 1) && !m_fin && ((m_win + m_k) < m_wr);
        e_last = e_rv && (m_k == m_K - 1);
        check("busy", busy, m_state == 1);
        check("done", done, m_state == 2);
        check("cfg_err", cfg_err, m_err);
        check("in_ready", in_ready, e_ir);
        check("spad_wen", spad_wen, vin && e_ir);
        check("rd_valid", rd_valid, e_rv);
        check("rd_last", rd_last, e_last);
        if (e_ir) check("spad_waddr", spad_waddr, m_wr % SR);
        if (e_rv) check("spad_raddr", spad_raddr, (m_win + m_k) % SR);
        check("stall_cnt", stall_cnt, m_stall);
        if (spad_wen) begin n_wen_obs++; wq.push_back(int'(spad_waddr)); end
        if (rd_valid) n_rv_obs++;
        if (done) n_done_obs++;
        if (rd_valid && rd_ready) begin
            rq.push_back(int'(spad_raddr));
            if (rd_last) begin lq.push_back(rq.size()); n_win_obs++; end
        end
        wf = vin && e_ir;
        rf = e_rv && rrdy;
        @(posedge clk);
        case (m_state)
            0: if (st) begin
                bad = (cfg_filt == 0) || (cfg_stride == 0) || (cfg_filt > SR) || (cfg_len < cfg_filt);
                m_err   = bad;
                m_stall = 0;
                if (bad) m_state = 2;
                else begin
                    m_state = 1;
                    m_L = cfg_len; m_K = cfg_filt; m_S = cfg_stride;
                    m_wr = 0; m_win = 0; m_k = 0; m_fin = 0;
                end
            end
            1: begin
`ifdef IFMAP_CTRL_PERF_EN
                if (!m_fin && !e_rv && m_stall < 65535) m_stall++;
`endif
                if (m_fin && m_wr == m_L) m_state = 2;
                else begin
                    if (wf) m_wr++;
                    if (rf) begin
                        if (m_k == m_K - 1) begin
                            m_k = 0;
                            m_win += m_S;
                            if (m_win + m_K > m_L) m_fin = 1;
                        end else m_k++;
                    end
                end
            end
            default: m_state = 0;
        endcase
        #1;
    endtask

    task automatic run_row(input int L, input int K, input int S, input int pv, input int pr,
                           input int rhold, input int vhold, input bit scramble);
        int cyc = 0;
        cfg_len = LW'(L); cfg_filt = KW'(K); cfg_stride = SW'(S);
        rq.delete(); lq.delete(); wq.delete();
        n_wen_obs = 0; n_rv_obs = 0; n_win_obs = 0; n_done_obs = 0; wen_at_hold = -1;
        step(0, 0, 1);
        if (scramble) begin
            cfg_len = LW'($urandom); cfg_filt = KW'($urandom); cfg_stride = SW'($urandom);
        end
        while (m_state != 0 && cyc < 6000) begin
            if (cyc == rhold && rhold > 0) wen_at_hold = n_wen_obs;
            step((cyc >= vhold) && ($urandom_range(99) < pv),
                 (cyc >= rhold) && ($urandom_range(99) < pr),
                 scramble && ($urandom_range(19) == 0));
            cyc++;
        end
        check("row_end_busy", busy, 0);
        check("row_done_pulses", n_done_obs, 1);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_waddr", spad_waddr, 0);
        check("rst_raddr", spad_raddr, 0);
        check("rst_stall", stall_cnt, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // L=5 K=3 S=1, free-running handshakes
        run_row(5, 3, 1, 100, 100, 0, 0, 0);
        check("t1_taps", rq.size(), 9);
        if (rq.size() == 9) for (int i = 0; i < 9; i++) check("t1_raddr_seq", rq[i], e1[i]);
        check("t1_windows", lq.size(), 3);
        if (lq.size() == 3) begin
            check("t1_last0", lq[0], 3);
            check("t1_last1", lq[1], 6);
            check("t1_last2", lq[2], 9);
        end

        // L=20 K=3 S=2, reader held off for 30 cycles: buffer fills, addresses wrap
        run_row(20, 3, 2, 100, 100, 30, 0, 0);
        check("t2_writes_before_reads", wen_at_hold, 12);
        check("t2_windows", n_win_obs, 9);
        check("t2_writes", n_wen_obs, 20);
        check("t2_taps", rq.size(), 27);
        if (rq.size() >= 18) begin
            check("t2_w5_tap0", rq[15], 10);
            check("t2_w5_tap1", rq[16], 11);
            check("t2_w5_tap2", rq[17], 0);
        end

        // L=7 K=2 S=3: stride larger than filter, trailing element drained
        run_row(7, 2, 3, 100, 100, 0, 0, 0);
        check("t3_taps", rq.size(), 4);
        if (rq.size() == 4) for (int i = 0; i < 4; i++) check("t3_raddr_seq", rq[i], e3[i]);
        check("t3_writes", n_wen_obs, 7);

        // Illegal configurations, then a legal one clears the flag
        run_row(5, 0, 1, 100, 100, 0, 0, 0);
        check("t4a_err", cfg_err, 1);
        check("t4a_no_wen", n_wen_obs, 0);
        check("t4a_no_rd", n_rv_obs, 0);
        run_row(2, 3, 1, 100, 100, 0, 0, 0);
        check("t4b_err", cfg_err, 1);
        check("t4b_no_wen", n_wen_obs, 0);
        check("t4b_no_rd", n_rv_obs, 0);
        run_row(6, 2, 2, 100, 100, 0, 0, 0);
        check("t4c_err_clear", cfg_err, 0);

        // Reset mid-row after 4 writes and 2 reads
        cfg_len = 8'd10; cfg_filt = 4'd3; cfg_stride = 4'd1;
        n_wen_obs = 0; rq.delete();
        step(0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 0);
        check("t5_pre_writes", n_wen_obs, 4);
        check("t5_pre_reads", rq.size(), 2);
        rst = 1'b1;
        #1;
        check("t5_in_ready", in_ready, 0);
        check("t5_spad_wen", spad_wen, 0);
        check("t5_rd_valid", rd_valid, 0);
        check("t5_rd_last", rd_last, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_waddr", spad_waddr, 0);
        check("t5_raddr", spad_raddr, 0);
        check("t5_stall", stall_cnt, 0);
        m_state = 0; m_err = 0; m_stall = 0; m_wr = 0; m_win = 0; m_k = 0; m_fin = 0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run_row(6, 3, 3, 100, 100, 0, 0, 0);
        if (wq.size() > 0) check("t5_restart_waddr", wq[0], 0);
        if (rq.size() > 0) check("t5_restart_raddr", rq[0], 0);

        // Starved reader: input held off for 10 running cycles
        run_row(4, 2, 1, 100, 100, 0, 10, 0);
`ifdef IFMAP_CTRL_PERF_EN
        check("t6_stall", stall_cnt, 11);
`else
        check("t6_stall", stall_cnt, 0);
`endif

        // Randomized rows, with occasional illegal configs and ignored start pulses
        for (int it = 0; it < 30; it++) begin
            int K, L, S;
            K = $urandom_range(1, 12);
            L = $urandom_range(K, 40);
            S = $urandom_range(1, 15);
            if (it % 7 == 6) begin
                if ($urandom_range(1) == 1) K = $urandom_range(13, 15);
                else L = K - 1;
            end
            run_row(L, K, S, $urandom_range(30, 100), $urandom_range(40, 100),
                    $urandom_range(0, 20), $urandom_range(0, 5), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
